vector_issue_sequencer: RTL and testbench

Parametrised instruction sequencer between the APU request interface and the vector datapath. Buffers up to DEPTH instructions, classifies each as config, scalar-result, reduction or element-wise, and steps it over ceil(vl/LANES) beats. Per beat it emits register addresses, a per-lane enable mask and first/last markers. Completions are returned in order with no idle cycle between back-to-back instructions.

---
 rtl/vector_issue_sequencer_if.sv | 58 +++++
 rtl/vector_issue_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_vector_issue_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_issue_sequencer_if.sv
// vector_issue_sequencer_if
//   Bundles the signals of the vector issue sequencer: the APU request and
//   response channel, the vector CSR view (vl/vsew), the datapath stall, and
//   the per-beat outputs sent to the vector datapath.
//
//   Modports
//     master : environment side (APU core plus datapath). It drives requests,
//              CSRs and stall, and receives the beats and completions.
//     slave  : sequencer side.
//
//   Signals
//     apu_req/apu_gnt/apu_instr/apu_scalar : instruction offer and grant
//     vl/vsew                              : current vector length and SEW code
//     stall                                : datapath cannot take the beat
//     beat_*/vs1_addr/vs2_addr/vd_addr     : per-beat control for the datapath
//     lane_en                              : live-element mask for the beat
//     apu_rvalid                           : in-order completion pulse
//     busy                                 : work queued or in flight
interface vector_issue_sequencer_if #(
  parameter int LANES  = 4,
  parameter int MAX_VL = 16
) ();
  localparam int VLW = $clog2(MAX_VL + 1);

  logic             apu_req;
  logic             apu_gnt;
  logic [31:0]      apu_instr;
  logic [31:0]      apu_scalar;
  logic [VLW-1:0]   vl;
  logic [1:0]       vsew;
  logic             stall;
  logic             beat_valid;
  logic             beat_first;
  logic             beat_last;
  logic [4:0]       vs1_addr;
  logic [4:0]       vs2_addr;
  logic [4:0]       vd_addr;
  logic [LANES-1:0] lane_en;
  logic [1:0]       beat_class;
  logic [31:0]      beat_instr;
  logic [31:0]      beat_scalar;
  logic             apu_rvalid;
  logic             busy;

  modport master (
    output apu_req, apu_instr, apu_scalar, vl, vsew, stall,
    input  apu_gnt, beat_valid, beat_first, beat_last, vs1_addr, vs2_addr,
           vd_addr, lane_en, beat_class, beat_instr, beat_scalar, apu_rvalid,
           busy
  );

  modport slave (
    input  apu_req, apu_instr, apu_scalar, vl, vsew, stall,
    output apu_gnt, beat_valid, beat_first, beat_last, vs1_addr, vs2_addr,
           vd_addr, lane_en, beat_class, beat_instr, beat_scalar, apu_rvalid,
           busy
  );
endinterface

// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer
//   Buffers up to DEPTH APU vector instructions. Each instruction is
//   classified (config / scalar-result / reduction / element-wise) and then
//   stepped over ceil(vl/LANES) beats. Each beat carries register addresses,
//   a lane-enable mask and first/last markers. Completions come back in order
//   as a one-cycle apu_rvalid pulse the cycle after the last beat is taken.
//
//   Ports
//     clk     : clock
//     n_reset : asynchronous, active-low reset
//     bus     : vector_issue_sequencer_if.slave (request, CSR, stall, beats)
//
//   The executing instruction stays at the FIFO head until its last beat is
//   taken. It therefore keeps its slot, and apu_gnt only reopens once it
//   retires.
module vector_issue_sequencer #(
  parameter int LANES  = 4,
  parameter int MAX_VL = 16,
  parameter int DEPTH  = 2
) (
  input logic                     clk,
  input logic                     n_reset,
  vector_issue_sequencer_if.slave bus
);
  localparam int VLW   = $clog2(MAX_VL + 1);
  localparam int LOG2L = $clog2(LANES);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [VLW:0] LANES_M1 = (VLW+1)'(LANES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [1:0] C_CONFIG = 2'd0;
  localparam logic [1:0] C_SCALAR = 2'd1;
  localparam logic [1:0] C_RED    = 2'd2;
  localparam logic [1:0] C_ELEM   = 2'd3;

  logic [31:0]    instr_mem_q  [DEPTH];
  logic [31:0]    scalar_mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [0:0]     state_q, state_d;
  logic [VLW-1:0] beat_q, beat_d;
  logic [VLW-1:0] vl_q;
  logic [1:0]     sew_q;
  logic           rvalid_q, rvalid_d;

  logic [31:0]    head_instr, head_scalar;
  logic [1:0]     head_cls;
  logic           head_step;
  logic           valid, first_c, last_c, take, enq, pop;
  logic [VLW-1:0] vl_eff;
  logic [1:0]     sew_raw, sew_eff;
  logic [VLW:0]   ceil_beats, nbeats;
  logic [4:0]     step_amt;
  logic [LANES-1:0] lane_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else return p + 1'b1;
  endfunction

  assign head_instr  = instr_mem_q[rptr_q];
  assign head_scalar = scalar_mem_q[rptr_q];

  // Decode the head entry. Only OP-V element-wise ops advance their register
  // fields per beat. Loads share the element-wise class but keep their fields
  // fixed. Unknown opcodes become a config-class no-op beat.
  always_comb begin
    head_cls  = C_CONFIG;
    head_step = 1'b0;
    if (head_instr[6:0] == 7'b1010111) begin
      if (head_instr[14:12] == 3'b111) begin
        head_cls = C_CONFIG;
      end else if (head_instr[14:12] == 3'b010 && head_instr[31:26] == 6'b010000) begin
        head_cls = C_SCALAR;
      end else if ((head_instr[14:12] == 3'b010 &&
                    (head_instr[31:26] == 6'b000000 || head_instr[31:26] == 6'b000111)) ||
                   head_instr[31:26] == 6'b110001) begin
        head_cls = C_RED;
      end else begin
        head_cls  = C_ELEM;
        head_step = 1'b1;
      end
    end else if (head_instr[6:0] == 7'b0000111 && head_instr[14:12] == 3'b111) begin
      head_cls = C_ELEM;
    end
  end

  // On the first beat, vl/vsew are read live, so a config beat that retired
  // on the previous edge is already visible. Later beats use the copy that
  // was captured when the first beat was taken.
  always_comb begin
    valid      = (state_q == S_EXEC);
    first_c    = (beat_q == '0);
    vl_eff     = first_c ? bus.vl : vl_q;
    sew_raw    = first_c ? bus.vsew : sew_q;
    sew_eff    = (sew_raw == 2'd3) ? 2'd2 : sew_raw;
    ceil_beats = ({1'b0, vl_eff} + LANES_M1) >> LOG2L;
    if (!head_cls[1] || ceil_beats == '0) nbeats = (VLW+1)'(1);
    else nbeats = ceil_beats;
    last_c     = ({1'b0, beat_q} == nbeats - 1'b1);
    step_amt   = 5'(32'(beat_q) << sew_eff);
    for (int i = 0; i < LANES; i++) begin
      lane_c[i] = head_cls[1] && (((32'(beat_q) << LOG2L) + 32'(i)) < 32'(vl_eff));
    end
  end

  assign take = valid & ~bus.stall;
  assign enq  = bus.apu_req & bus.apu_gnt;

  // Beat outputs are forced to zero whenever no beat is in flight.
  assign bus.apu_gnt     = (count_q < CW'(DEPTH));
  assign bus.beat_valid  = valid;
  assign bus.beat_first  = valid & first_c;
  assign bus.beat_last   = valid & last_c;
  assign bus.vs1_addr    = valid ? (head_step ? head_instr[19:15] + step_amt : head_instr[19:15]) : '0;
  assign bus.vs2_addr    = valid ? (head_step ? head_instr[24:20] + step_amt : head_instr[24:20]) : '0;
  assign bus.vd_addr     = valid ? (head_step ? head_instr[11:7]  + step_amt : head_instr[11:7])  : '0;
  assign bus.lane_en     = valid ? lane_c : '0;
  assign bus.beat_class  = valid ? head_cls : '0;
  assign bus.beat_instr  = valid ? head_instr : '0;
  assign bus.beat_scalar = valid ? head_scalar : '0;
  assign bus.apu_rvalid  = rvalid_q;
  assign bus.busy        = (count_q != '0) | valid;

  // When the last beat is taken, the head is retired. The FSM stays in EXEC
  // only if another entry is already queued behind it, which gives the
  // gap-free back-to-back behaviour.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_EXEC;
          beat_d  = '0;
        end
      end
      S_EXEC: begin
        if (take) begin
          if (last_c) begin
            rvalid_d = 1'b1;
            pop      = 1'b1;
            beat_d   = '0;
            if (count_q == CW'(1)) state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (enq && !pop) count_d = count_q + 1'b1;
    else if (!enq && pop) count_d = count_q - 1'b1;
  end

  // The storage array needs no reset: every read of it is qualified by count
  // or by the EXEC state.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem_q[wptr_q]  <= bus.apu_instr;
      scalar_mem_q[wptr_q] <= bus.apu_scalar;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      beat_q   <= '0;
      vl_q     <= '0;
      sew_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (enq) wptr_q <= ptr_inc(wptr_q);
      if (pop) rptr_q <= ptr_inc(rptr_q);
      count_q  <= count_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      if (take && first_c) begin
        vl_q  <= bus.vl;
        sew_q <= bus.vsew;
      end
    end
  end
endmodule

// File: tb/tb_vector_issue_sequencer.sv
// tb_vector_issue_sequencer
//   Scoreboard bench for vector_issue_sequencer (LANES=4, MAX_VL=16, DEPTH=2).
//   Each accepted instruction pushes its expected beats to a queue. A negedge
//   monitor pops the queue as beats are taken and checks the completion
//   pulse. Scenario tasks add their own inline checks.
module tb_vector_issue_sequencer;
  localparam int LANES  = 4;
  localparam int MAX_VL = 16;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [3:0]  lane;
    logic [1:0]  cls;
    logic [31:0] instr;
    logic [31:0] scalar;
  } beat_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  vector_issue_sequencer_if #(.LANES(LANES), .MAX_VL(MAX_VL)) sif ();

  vector_issue_sequencer #(.LANES(LANES), .MAX_VL(MAX_VL), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (sif)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rv_seen = 0;
  bit    mon_en = 1'b0;
  bit    rv_exp = 1'b0;
  beat_t sb[$];
  beat_t mexp, mgot;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic [4:0] vs2,
                                     input logic [4:0] vs1, input logic [2:0] f3,
                                     input logic [4:0] vd, input logic [6:0] op);
    return {f6, 1'b1, vs2, vs1, f3, vd, op};
  endfunction

  function automatic beat_t got_beat();
    beat_t g;
    g.first  = sif.beat_first;
    g.last   = sif.beat_last;
    g.vs1    = sif.vs1_addr;
    g.vs2    = sif.vs2_addr;
    g.vd     = sif.vd_addr;
    g.lane   = sif.lane_en;
    g.cls    = sif.beat_class;
    g.instr  = sif.beat_instr;
    g.scalar = sif.beat_scalar;
    return g;
  endfunction

  // Reference model: the beats an instruction must produce, given the vl/vsew
  // that will be live on its first beat.
  task automatic push_expected(input logic [31:0] ins, input logic [31:0] sc,
                               input int vlx, input int sewx);
    int    cls, nb, sew, inc;
    bit    step;
    beat_t e;
    cls  = 0;
    step = 1'b0;
    if (ins[6:0] == 7'h57) begin
      if (ins[14:12] == 3'd7) cls = 0;
      else if (ins[14:12] == 3'd2 && ins[31:26] == 6'h10) cls = 1;
      else if ((ins[14:12] == 3'd2 && (ins[31:26] == 6'h00 || ins[31:26] == 6'h07)) ||
               ins[31:26] == 6'h31) cls = 2;
      else begin cls = 3; step = 1'b1; end
    end else if (ins[6:0] == 7'h07 && ins[14:12] == 3'd7) begin
      cls = 3;
    end
    sew = (sewx == 3) ? 2 : sewx;
    if (cls < 2) nb = 1;
    else begin
      nb = (vlx + LANES - 1) / LANES;
      if (nb == 0) nb = 1;
    end
    for (int b = 0; b < nb; b++) begin
      inc      = step ? b * (1 << sew) : 0;
      e.first  = (b == 0);
      e.last   = (b == nb - 1);
      e.vs1    = 5'((int'(ins[19:15]) + inc) % 32);
      e.vs2    = 5'((int'(ins[24:20]) + inc) % 32);
      e.vd     = 5'((int'(ins[11:7]) + inc) % 32);
      for (int i = 0; i < LANES; i++) e.lane[i] = (cls >= 2) && (b * LANES + i < vlx);
      e.cls    = 2'(cls);
      e.instr  = ins;
      e.scalar = sc;
      sb.push_back(e);
    end
  endtask

  // Offer one instruction. This returns just after the accepting edge. A
  // caller must be positioned just after a posedge.
  task automatic offer(input logic [31:0] ins, input logic [31:0] sc,
                       input int vlx, input int sewx);
    bit ok;
    ok = 1'b0;
    sif.apu_instr  = ins;
    sif.apu_scalar = sc;
    sif.apu_req    = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (sif.apu_gnt === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      push_expected(ins, sc, vlx, sewx);
      #1;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL offer_timeout: instr=%h never granted, gnt=%b required 1", ins, sif.apu_gnt);
    end
    sif.apu_req = 1'b0;
  endtask

  // Wait until the sequencer is idle and everything expected has been seen.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (sif.busy === 1'b0 && sb.size() == 0 && !rv_exp) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: busy=%b pending=%0d required busy=0 pending=0", sif.busy, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every beat is compared with the queue head, which is
  // popped only when the beat is taken. apu_rvalid must pulse exactly the
  // cycle after an expected last beat is taken.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sif.apu_rvalid !== rv_exp) begin
        errors++;
        $display("[TB] FAIL rvalid: got %b required %b at cycle %0d", sif.apu_rvalid, rv_exp, cyc);
      end
      if (sif.apu_rvalid === 1'b1) rv_seen++;
      rv_exp = 1'b0;
      if (sif.beat_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: beat_valid=1 with instr=%h, required no beat", sif.beat_instr);
        end else begin
          mexp = sb[0];
          mgot = got_beat();
          if (mgot !== mexp) begin
            errors++;
            $display("[TB] FAIL beat: got f=%b l=%b vs1=%0d vs2=%0d vd=%0d lane=%b cls=%0d instr=%h sc=%h required f=%b l=%b vs1=%0d vs2=%0d vd=%0d lane=%b cls=%0d instr=%h sc=%h",
                     mgot.first, mgot.last, mgot.vs1, mgot.vs2, mgot.vd, mgot.lane, mgot.cls, mgot.instr, mgot.scalar,
                     mexp.first, mexp.last, mexp.vs1, mexp.vs2, mexp.vd, mexp.lane, mexp.cls, mexp.instr, mexp.scalar);
          end
          if (sif.stall === 1'b0) begin
            void'(sb.pop_front());
            if (mexp.last) rv_exp = 1'b1;
          end
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sif.beat_valid, sif.beat_first, sif.beat_last, sif.vs1_addr, sif.vs2_addr, sif.vd_addr,
         sif.lane_en, sif.beat_class, sif.beat_instr, sif.beat_scalar, sif.apu_rvalid, sif.busy} !== '0 ||
        sif.apu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b busy=%b rvalid=%b gnt=%b required 0/0/0/1",
               sif.beat_valid, sif.busy, sif.apu_rvalid, sif.apu_gnt);
    end
    @(posedge clk);
    #1 n_reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (sif.beat_valid !== 1'b0 || sif.busy !== 1'b0 || sif.apu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset: valid=%b busy=%b gnt=%b required 0/0/1", sif.beat_valid, sif.busy, sif.apu_gnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_elementwise();
    int acc, fcyc, rcyc, base;
    base = rv_seen;
    sif.vl = 10;
    sif.vsew = 0;
    offer(mk(6'h00, 5'd16, 5'd24, 3'd0, 5'd8, 7'h57), 32'h1111_0001, 10, 0);
    acc  = cyc;
    fcyc = -1;
    rcyc = -1;
    for (int k = 0; k < 20 && rcyc < 0; k++) begin
      @(negedge clk);
      if (sif.beat_valid === 1'b1 && fcyc < 0) fcyc = cyc;
      if (sif.apu_rvalid === 1'b1) rcyc = cyc;
    end
    checks++;
    if (fcyc - acc != 1) begin
      errors++;
      $display("[TB] FAIL first_beat_latency: got %0d required 1", fcyc - acc);
    end
    checks++;
    if (rcyc - acc != 4) begin
      errors++;
      $display("[TB] FAIL rvalid_latency: got %0d required 4", rcyc - acc);
    end
    drain();
    sif.vl = 8;
    sif.vsew = 1;
    offer(mk(6'h02, 5'd4, 5'd2, 3'd0, 5'd30, 7'h57), 32'h2222_0002, 8, 1);
    drain();
    checks++;
    if (rv_seen - base != 2) begin
      errors++;
      $display("[TB] FAIL elem_rvalid_count: got %0d required 2", rv_seen - base);
    end
  endtask

  task automatic test_reduction();
    int base;
    base = rv_seen;
    sif.vl = 7;
    sif.vsew = 0;
    offer(mk(6'h00, 5'd5, 5'd7, 3'd2, 5'd3, 7'h57), 32'h3333_0003, 7, 0);
    drain();
    checks++;
    if (rv_seen - base != 1) begin
      errors++;
      $display("[TB] FAIL red_rvalid_count: got %0d required 1", rv_seen - base);
    end
  endtask

  task automatic test_classes();
    int base;
    base = rv_seen;
    sif.vl = 10;
    sif.vsew = 3;
    offer(mk(6'h10, 5'd9, 5'd0, 3'd2, 5'd5, 7'h57), 32'h4444_0004, 10, 3);
    offer(mk(6'h00, 5'd0, 5'd6, 3'd7, 5'd4, 7'h07), 32'h4444_0005, 10, 3);
    offer(32'h00B5_0533, 32'h4444_0006, 10, 3);
    offer(mk(6'h07, 5'd11, 5'd12, 3'd2, 5'd13, 7'h57), 32'h4444_0007, 10, 3);
    offer(mk(6'h31, 5'd14, 5'd15, 3'd0, 5'd17, 7'h57), 32'h4444_0008, 10, 3);
    offer(mk(6'h00, 5'd16, 5'd24, 3'd0, 5'd8, 7'h57), 32'h4444_0009, 10, 3);
    drain();
    sif.vl = 0;
    sif.vsew = 0;
    offer(mk(6'h00, 5'd1, 5'd2, 3'd0, 5'd3, 7'h57), 32'h4444_000A, 0, 0);
    drain();
    checks++;
    if (rv_seen - base != 7) begin
      errors++;
      $display("[TB] FAIL class_rvalid_count: got %0d required 7", rv_seen - base);
    end
  endtask

  task automatic test_back_to_back();
    int cfg_cyc, add_cyc;
    bit upd;
    cfg_cyc = -1;
    add_cyc = -1;
    upd = 1'b0;
    sif.vl = 4;
    sif.vsew = 0;
    offer({1'b0, 11'h008, 5'd1, 3'd7, 5'd2, 7'h57}, 32'h0000_000C, 4, 0);
    offer(mk(6'h00, 5'd16, 5'd24, 3'd0, 5'd8, 7'h57), 32'h5555_0001, 12, 0);
    for (int k = 0; k < 20 && add_cyc < 0; k++) begin
      @(negedge clk);
      if (sif.beat_valid === 1'b1 && sif.beat_class === 2'd0 && cfg_cyc < 0) begin
        cfg_cyc = cyc;
        upd = 1'b1;
      end
      if (sif.beat_valid === 1'b1 && sif.beat_first === 1'b1 && sif.beat_class === 2'd3) add_cyc = cyc;
      @(posedge clk);
      #1;
      if (upd) sif.vl = 12;
    end
    checks++;
    if (cfg_cyc < 0 || add_cyc - cfg_cyc != 1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: config beat cycle %0d, vadd first beat cycle %0d, required distance 1", cfg_cyc, add_cyc);
    end
    drain();
  endtask

  task automatic test_stall();
    int    base, rv_at_c;
    beat_t snap, cur;
    base = rv_seen;
    rv_at_c = -1;
    sif.vl = 4;
    sif.vsew = 0;
    sif.stall = 1'b1;
    offer(mk(6'h00, 5'd1, 5'd2, 3'd0, 5'd8, 7'h57), 32'h6666_0001, 4, 0);
    offer(mk(6'h00, 5'd1, 5'd2, 3'd0, 5'd12, 7'h57), 32'h6666_0002, 4, 0);
    fork
      begin
        offer(mk(6'h00, 5'd1, 5'd2, 3'd0, 5'd20, 7'h57), 32'h6666_0003, 4, 0);
        rv_at_c = rv_seen - base;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          cur = got_beat();
          checks++;
          if (sif.apu_gnt !== 1'b0 || sif.beat_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_gnt: gnt=%b valid=%b required 0/1", sif.apu_gnt, sif.beat_valid);
          end
          if (k == 0) snap = cur;
          else begin
            checks++;
            if (cur !== snap) begin
              errors++;
              $display("[TB] FAIL stall_hold: vd=%0d lane=%b instr=%h required vd=%0d lane=%b instr=%h",
                       cur.vd, cur.lane, cur.instr, snap.vd, snap.lane, snap.instr);
            end
          end
        end
        @(posedge clk);
        #1 sif.stall = 1'b0;
      end
    join
    checks++;
    if (rv_at_c != 1) begin
      errors++;
      $display("[TB] FAIL third_accept: completions before third grant %0d required 1", rv_at_c);
    end
    drain();
    checks++;
    if (rv_seen - base != 3) begin
      errors++;
      $display("[TB] FAIL stall_rvalid_count: got %0d required 3", rv_seen - base);
    end
  endtask

  task automatic test_reset_mid();
    sif.vl = 16;
    sif.vsew = 0;
    offer(mk(6'h00, 5'd1, 5'd2, 3'd0, 5'd3, 7'h57), 32'h7777_0001, 16, 0);
    offer(mk(6'h00, 5'd4, 5'd5, 3'd0, 5'd6, 7'h57), 32'h7777_0002, 16, 0);
    @(negedge clk);
    checks++;
    if (sif.beat_valid !== 1'b1 || sif.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_beat: valid=%b busy=%b required 1/1", sif.beat_valid, sif.busy);
    end
    mon_en = 1'b0;
    #1 n_reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({sif.beat_valid, sif.beat_first, sif.beat_last, sif.vs1_addr, sif.vs2_addr, sif.vd_addr,
           sif.lane_en, sif.beat_class, sif.beat_instr, sif.beat_scalar, sif.apu_rvalid, sif.busy} !== '0 ||
          sif.apu_gnt !== 1'b1) begin
        errors++;
        $display("[TB] FAIL in_reset: valid=%b vd=%0d busy=%b rvalid=%b gnt=%b required 0/0/0/0/1",
                 sif.beat_valid, sif.vd_addr, sif.busy, sif.apu_rvalid, sif.apu_gnt);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 n_reset = 1'b1;
    sb.delete();
    rv_exp = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (sif.busy !== 1'b0 || sif.beat_valid !== 1'b0 || sif.apu_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle: busy=%b valid=%b rvalid=%b required 0/0/0",
                 sif.busy, sif.beat_valid, sif.apu_rvalid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sif.apu_req    = 1'b0;
    sif.apu_instr  = '0;
    sif.apu_scalar = '0;
    sif.vl         = '0;
    sif.vsew       = '0;
    sif.stall      = 1'b0;
    test_reset();
    test_elementwise();
    test_reduction();
    test_classes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
